// File: rtl/cache_axi_rd_arbiter.sv
// Shares one AXI read channel between icache refill, dcache refill and uncached loads.
// Optional round-robin grant when CACHE_ARB_RR_EN is defined; fixed priority d > u > i otherwise.
module cache_axi_rd_arbiter (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_req,
  input  logic         d_req,
  input  logic         u_req,
  input  logic [31:0]  i_addr,
  input  logic [31:0]  d_addr,
  input  logic [31:0]  u_addr,
  output logic         i_rend,
  output logic         d_rend,
  output logic         u_rend,
  output logic [255:0] i_line,
  output logic [255:0] d_line,
  output logic [31:0]  u_rdata,
  output logic [3:0]   arid,
  output logic [31:0]  araddr,
  output logic [7:0]   arlen,
  output logic [2:0]   arsize,
  output logic [1:0]   arburst,
  output logic         arvalid,
  input  logic         arready,
  input  logic [3:0]   rid,
  input  logic [31:0]  rdata,
  input  logic         rlast,
  input  logic         rvalid,
  output logic         rready
);

  localparam logic [3:0] ID_I = 4'd0;
  localparam logic [3:0] ID_D = 4'd1;
  localparam logic [3:0] ID_U = 4'd2;

  localparam logic [1:0] SEL_I = 2'd0;
  localparam logic [1:0] SEL_D = 2'd1;
  localparam logic [1:0] SEL_U = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_AR   = 2'd1,
    ST_R    = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  state_t         state_r;
  logic [1:0]     grant_r;
  logic [2:0]     pend_r;
  logic [26:0]    addr_i_r;
  logic [26:0]    addr_d_r;
  logic [31:0]    addr_u_r;
  logic [2:0]     beat_cnt_r;
  logic [255:0]   buf_r;

  logic [2:0]     busy_s;
  logic [2:0]     set_s;
  logic [2:0]     clr_s;
  logic           win_vld_s;
  logic [1:0]     win_s;
  logic [31:0]    win_araddr_s;
  logic           beat_s;
  logic [255:0]   buf_nxt_s;
  logic           unused_s;

  // rid is not checked and cache line offsets are never forwarded.
  assign unused_s = ^{rid, i_addr[4:0], d_addr[4:0]};

  function automatic logic [3:0] sel_to_id(input logic [1:0] sel);
    logic [3:0] id;
    case (sel)
      SEL_I:   id = ID_I;
      SEL_D:   id = ID_D;
      SEL_U:   id = ID_U;
      default: id = ID_I;
    endcase
    return id;
  endfunction

`ifdef CACHE_ARB_RR_EN
  logic [1:0] ptr_r;

  // Round-robin search i -> d -> u starting just after the last winner.
  always_comb begin
    win_s = SEL_I;
    case (ptr_r)
      SEL_I: begin
        if (pend_r[1])      win_s = SEL_D;
        else if (pend_r[2]) win_s = SEL_U;
        else                win_s = SEL_I;
      end
      SEL_D: begin
        if (pend_r[2])      win_s = SEL_U;
        else if (pend_r[0]) win_s = SEL_I;
        else                win_s = SEL_D;
      end
      default: begin
        if (pend_r[0])      win_s = SEL_I;
        else if (pend_r[1]) win_s = SEL_D;
        else                win_s = SEL_U;
      end
    endcase
  end

  // Last-grant pointer; starts at u so the first search order is i, d, u.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_r <= SEL_U;
    end else if (state_r == ST_IDLE && win_vld_s) begin
      ptr_r <= win_s;
    end else begin
      ptr_r <= ptr_r;
    end
  end
`else
  // Fixed priority d > u > i.
  always_comb begin
    win_s = SEL_I;
    if (pend_r[1])      win_s = SEL_D;
    else if (pend_r[2]) win_s = SEL_U;
    else                win_s = SEL_I;
  end
`endif

  // Winner address already shaped for the AR channel.
  always_comb begin
    win_vld_s    = |pend_r;
    win_araddr_s = 32'd0;
    case (win_s)
      SEL_I:   win_araddr_s = {addr_i_r, 5'd0};
      SEL_D:   win_araddr_s = {addr_d_r, 5'd0};
      SEL_U:   win_araddr_s = addr_u_r;
      default: win_araddr_s = 32'd0;
    endcase
  end

  // Requester bookkeeping: in-service blocks new requests, DONE no longer counts as in service.
  always_comb begin
    busy_s = 3'b000;
    clr_s  = 3'b000;
    if (state_r == ST_AR || state_r == ST_R) begin
      busy_s[grant_r] = 1'b1;
    end else begin
      busy_s = 3'b000;
    end
    if (state_r == ST_IDLE && win_vld_s) begin
      clr_s[win_s] = 1'b1;
    end else begin
      clr_s = 3'b000;
    end
    set_s = {u_req, d_req, i_req} & ~pend_r & ~busy_s;
  end

  // Beat capture into the line buffer at the current beat index.
  always_comb begin
    beat_s    = rvalid && rready && (state_r == ST_R);
    buf_nxt_s = buf_r;
    if (beat_s) begin
      buf_nxt_s[{beat_cnt_r, 5'd0} +: 32] = rdata;
    end else begin
      buf_nxt_s = buf_r;
    end
  end

  // Pending flags and captured request addresses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_r   <= 3'b000;
      addr_i_r <= 27'd0;
      addr_d_r <= 27'd0;
      addr_u_r <= 32'd0;
    end else begin
      pend_r <= (pend_r & ~clr_s) | set_s;
      if (set_s[0]) addr_i_r <= i_addr[31:5];
      else          addr_i_r <= addr_i_r;
      if (set_s[1]) addr_d_r <= d_addr[31:5];
      else          addr_d_r <= addr_d_r;
      if (set_s[2]) addr_u_r <= u_addr;
      else          addr_u_r <= addr_u_r;
    end
  end

  // Transaction FSM with registered AXI and completion outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= ST_IDLE;
      grant_r    <= SEL_I;
      beat_cnt_r <= 3'd0;
      buf_r      <= 256'd0;
      arvalid    <= 1'b0;
      rready     <= 1'b0;
      arid       <= 4'd0;
      araddr     <= 32'd0;
      arlen      <= 8'd0;
      arsize     <= 3'd0;
      arburst    <= 2'b00;
      i_rend     <= 1'b0;
      d_rend     <= 1'b0;
      u_rend     <= 1'b0;
      i_line     <= 256'd0;
      d_line     <= 256'd0;
      u_rdata    <= 32'd0;
    end else begin
      i_rend <= 1'b0;
      d_rend <= 1'b0;
      u_rend <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (win_vld_s) begin
            state_r    <= ST_AR;
            grant_r    <= win_s;
            beat_cnt_r <= 3'd0;
            arvalid    <= 1'b1;
            arid       <= sel_to_id(win_s);
            araddr     <= win_araddr_s;
            arlen      <= (win_s == SEL_U) ? 8'd0 : 8'd7;
            arsize     <= 3'd2;
            arburst    <= 2'b01;
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_AR: begin
          if (arready) begin
            arvalid <= 1'b0;
            rready  <= 1'b1;
            state_r <= ST_R;
          end else begin
            state_r <= ST_AR;
          end
        end
        ST_R: begin
          if (beat_s) begin
            buf_r      <= buf_nxt_s;
            beat_cnt_r <= beat_cnt_r + 3'd1;
            if (rlast) begin
              rready  <= 1'b0;
              state_r <= ST_DONE;
              case (grant_r)
                SEL_I: begin
                  i_line <= buf_nxt_s;
                  i_rend <= 1'b1;
                end
                SEL_D: begin
                  d_line <= buf_nxt_s;
                  d_rend <= 1'b1;
                end
                SEL_U: begin
                  u_rdata <= rdata;
                  u_rend  <= 1'b1;
                end
                default: begin
                  i_rend <= 1'b0;
                end
              endcase
            end else begin
              state_r <= ST_R;
            end
          end else begin
            state_r <= ST_R;
          end
        end
        ST_DONE: begin
          state_r <= ST_IDLE;
        end
        default: begin
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
